// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, with a saturating shift counter.
// Define ROTATE_EN to make shifts with rot=1 rotate instead of taking serial input.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sdi_r,
    input  logic             sdi_l,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             so_r,
    output logic             so_l,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    mode_t            mode_sel;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic [CW-1:0]    cnt_inc;
    logic             shift_in_r;
    logic             shift_in_l;

    assign mode_sel = mode_t'(mode);

`ifdef ROTATE_EN
    // Rotation feeds the bit falling off the far end back in, replacing serial input.
    assign shift_in_r = rot ? q[0] : sdi_r;
    assign shift_in_l = rot ? q[WIDTH-1] : sdi_l;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign shift_in_r = sdi_r;
    assign shift_in_l = sdi_l;
`endif

    assign cnt_inc = (cnt == FULL) ? cnt : cnt + CW'(1);

    always_comb begin
        q_next   = q;
        cnt_next = cnt;
        case (mode_sel)
            MODE_SHR: begin
                q_next   = {shift_in_r, q[WIDTH-1:1]};
                cnt_next = cnt_inc;
            end
            MODE_SHL: begin
                q_next   = {q[WIDTH-2:0], shift_in_l};
                cnt_next = cnt_inc;
            end
            MODE_LOAD: begin
                q_next   = d;
                cnt_next = '0;
            end
            default: begin
                q_next   = q;
                cnt_next = cnt;
            end
        endcase
    end

    // done is registered from the next count so it always tracks cnt == WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (en) begin
            q    <= q_next;
            cnt  <= cnt_next;
            done <= (cnt_next == FULL);
        end
    end

    assign qn   = ~q;
    assign so_r = q[0];
    assign so_l = q[WIDTH-1];

endmodule
